// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder. MDC/MDIO are oversampled on clk; frames are
// decoded by a small FSM that raises register read/write strobes and drives
// read data back onto the shared MDIO line.
module mdio_responder #(
   parameter logic [4:0] PHY_ADDR     = 5'd1,
   parameter int         PREAMBLE_MIN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   output logic [4:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_wr_en,
   output logic        reg_rd_en,
   input  logic [15:0] reg_rdata,
   output logic        frame_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_SKIP
   } state_t;

   // ones counter saturates at 63, so the threshold is held in 7 bits
   localparam logic [6:0] PRE_MIN = 7'(PREAMBLE_MIN);

   state_t      state_q, state_d;
   logic        mdc_s1_q, mdc_s2_q, mdc_prev_q, mdio_s1_q, mdio_s2_q;
   logic        rise, fall, bit_s;
   logic [5:0]  ones_q, ones_d;
   logic [4:0]  bcnt_q, bcnt_d;
   logic [15:0] shift_q, shift_d;
   logic        rd_op_q, rd_op_d, match_q, match_d, rd_lat_q, rd_lat_d;
   logic [4:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        oe_q, oe_d, o_q, o_d, wr_q, wr_d, rd_q, rd_d, err_q, err_d;

   // two-flop synchronizers plus a history flop for MDC edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdc_s1_q   <= 1'b0;
         mdc_s2_q   <= 1'b0;
         mdc_prev_q <= 1'b0;
         mdio_s1_q  <= 1'b0;
         mdio_s2_q  <= 1'b0;
      end else begin
         mdc_s1_q   <= mdc_i;
         mdc_s2_q   <= mdc_s1_q;
         mdc_prev_q <= mdc_s2_q;
         mdio_s1_q  <= mdio_i;
         mdio_s2_q  <= mdio_s1_q;
      end
   end

   assign rise  = mdc_s2_q & ~mdc_prev_q;
   assign fall  = ~mdc_s2_q & mdc_prev_q;
   assign bit_s = mdio_s2_q;

   // frame decode: next state, shift register, strobes and pad drive
   always_comb begin
      state_d  = state_q;
      ones_d   = ones_q;
      bcnt_d   = bcnt_q;
      shift_d  = shift_q;
      rd_op_d  = rd_op_q;
      match_d  = match_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      oe_d     = oe_q;
      o_d      = o_q;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      err_d    = 1'b0;
      rd_lat_d = rd_q;
      // read data arrives the clk after the strobe; nothing else uses the
      // shift register in that window
      if (rd_lat_q) shift_d = reg_rdata;
      case (state_q)
         S_PRE: if (rise) begin
            if (bit_s) begin
               ones_d = (ones_q == 6'd63) ? ones_q : ones_q + 6'd1;
            end else begin
               ones_d = 6'd0;
               if ({1'b0, ones_q} >= PRE_MIN) state_d = S_ST;
            end
         end
         S_ST: if (rise) begin
            bcnt_d = 5'd0;
            if (bit_s) state_d = S_OP;
            else begin
               err_d   = 1'b1;
               state_d = S_PRE;
            end
         end
         S_OP: if (rise) begin
            shift_d = {shift_q[14:0], bit_s};
            bcnt_d  = bcnt_q + 5'd1;
            if (bcnt_q == 5'd1) begin
               bcnt_d = 5'd0;
               case ({shift_q[0], bit_s})
                  2'b10: begin rd_op_d = 1'b1; state_d = S_PHY; end
                  2'b01: begin rd_op_d = 1'b0; state_d = S_PHY; end
                  default: begin err_d = 1'b1; state_d = S_PRE; end
               endcase
            end
         end
         S_PHY: if (rise) begin
            shift_d = {shift_q[14:0], bit_s};
            bcnt_d  = bcnt_q + 5'd1;
            if (bcnt_q == 5'd4) begin
               bcnt_d  = 5'd0;
               match_d = ({shift_q[3:0], bit_s} == PHY_ADDR);
               state_d = S_REG;
            end
         end
         S_REG: if (rise) begin
            shift_d = {shift_q[14:0], bit_s};
            bcnt_d  = bcnt_q + 5'd1;
            if (bcnt_q == 5'd4) begin
               bcnt_d = 5'd0;
               addr_d = {shift_q[3:0], bit_s};
               if (!match_q) state_d = S_SKIP;
               else begin
                  state_d = S_TA;
                  rd_d    = rd_op_q;
               end
            end
         end
         S_TA: begin
            if (rise) begin
               bcnt_d = bcnt_q + 5'd1;
               if (!rd_op_q) begin
                  shift_d = {shift_q[14:0], bit_s};
                  if (bcnt_q == 5'd1) begin
                     bcnt_d = 5'd0;
                     if ({shift_q[0], bit_s} == 2'b10) state_d = S_DATA;
                     else begin
                        // bad turnaround: swallow the 16 data bits
                        err_d   = 1'b1;
                        bcnt_d  = 5'd2;
                        state_d = S_SKIP;
                     end
                  end
               end
            end else if (fall && rd_op_q && bcnt_q == 5'd1) begin
               // fall ending TA bit 1: take the line and present TA bit 2 = 0
               oe_d    = 1'b1;
               o_d     = 1'b0;
               bcnt_d  = 5'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rd_op_q) begin
               if (fall) begin
                  if (bcnt_q == 5'd16) begin
                     oe_d    = 1'b0;
                     o_d     = 1'b0;
                     bcnt_d  = 5'd0;
                     state_d = S_PRE;
                  end else begin
                     o_d     = shift_q[15];
                     shift_d = {shift_q[14:0], 1'b0};
                     bcnt_d  = bcnt_q + 5'd1;
                  end
               end
            end else if (rise) begin
               shift_d = {shift_q[14:0], bit_s};
               bcnt_d  = bcnt_q + 5'd1;
               if (bcnt_q == 5'd15) begin
                  wdata_d = {shift_q[14:0], bit_s};
                  wr_d    = 1'b1;
                  bcnt_d  = 5'd0;
                  state_d = S_PRE;
               end
            end
         end
         S_SKIP: if (rise) begin
            bcnt_d = bcnt_q + 5'd1;
            if (bcnt_q == 5'd17) begin
               bcnt_d  = 5'd0;
               state_d = S_PRE;
            end
         end
         default: state_d = S_PRE;
      endcase
   end

   // state and datapath registers; reset drops the pad drive immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_PRE;
         ones_q   <= 6'd0;
         bcnt_q   <= 5'd0;
         shift_q  <= 16'd0;
         rd_op_q  <= 1'b0;
         match_q  <= 1'b0;
         rd_lat_q <= 1'b0;
         addr_q   <= 5'd0;
         wdata_q  <= 16'd0;
         oe_q     <= 1'b0;
         o_q      <= 1'b0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ones_q   <= ones_d;
         bcnt_q   <= bcnt_d;
         shift_q  <= shift_d;
         rd_op_q  <= rd_op_d;
         match_q  <= match_d;
         rd_lat_q <= rd_lat_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         oe_q     <= oe_d;
         o_q      <= o_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         err_q    <= err_d;
      end
   end

   assign mdio_o    = o_q;
   assign mdio_oe   = oe_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_wr_en = wr_q;
   assign reg_rd_en = rd_q;
   assign frame_err = err_q;
   assign busy      = (state_q != S_PRE);

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDIO manager model drives frames bit by bit,
// a monitor counts strobes/pulses, and expectations come from a directed
// table plus a frame-level reference model for random frames.
module tb_mdio_responder;

   localparam int MDC_HALF = 8;   // clk cycles per MDC half period

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mdc;
   logic        mgr_oe, mgr_bit;
   logic        mdio_bus;
   logic        mdio_o, mdio_oe;
   logic [4:0]  reg_addr;
   logic [15:0] reg_wdata, reg_rdata;
   logic        reg_wr_en, reg_rd_en, frame_err, busy;

   int checks = 0;
   int errors = 0;

   // monitor counters (only the monitor writes these)
   int n_rd = 0, n_wr = 0, n_err = 0, n_oe = 0, n_bz = 0, n_both = 0;
   logic [4:0]  cap_addr = 5'd0;
   logic [15:0] cap_wd = 16'd0;

   // open-drain style bus with pull-up when nobody drives
   assign mdio_bus = mdio_oe ? mdio_o : (mgr_oe ? mgr_bit : 1'b1);

   always #5 clk = ~clk;

   mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_MIN(32)) dut (
      .clk(clk), .rst_n(rst_n), .mdc_i(mdc), .mdio_i(mdio_bus),
      .mdio_o(mdio_o), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
      .reg_rdata(reg_rdata), .frame_err(frame_err), .busy(busy)
   );

   // per-clk observation of strobes and pad drive
   always @(negedge clk) begin
      if (reg_rd_en) begin n_rd++; cap_addr = reg_addr; end
      if (reg_wr_en) begin n_wr++; cap_addr = reg_addr; cap_wd = reg_wdata; end
      if (frame_err) n_err++;
      if (mdio_oe) n_oe++;
      if (busy) n_bz++;
      if (reg_rd_en && reg_wr_en) n_both++;
   end

   typedef struct {
      int          pre;
      logic [1:0]  st, op;
      logic [4:0]  phy, ra;
      logic [1:0]  ta;
      logic [15:0] wd, rd;
      int          e_rd, e_wr, e_err, e_busy;
      logic [15:0] e_dat;   // read: bits seen on the bus; write: reg_wdata
   } vec_t;

   function automatic vec_t mk(int pre, logic [1:0] st, logic [1:0] op,
                               logic [4:0] phy, logic [4:0] ra, logic [1:0] ta,
                               logic [15:0] wd, logic [15:0] rd, int e_rd,
                               int e_wr, int e_err, int e_busy, logic [15:0] e_dat);
      vec_t v;
      v.pre = pre; v.st = st; v.op = op; v.phy = phy; v.ra = ra; v.ta = ta;
      v.wd = wd; v.rd = rd; v.e_rd = e_rd; v.e_wr = e_wr; v.e_err = e_err;
      v.e_busy = e_busy; v.e_dat = e_dat;
      return v;
   endfunction

   // frame-level reference: what a Clause-22 responder at address 1 must do
   // with a frame preceded by a full preamble
   function automatic vec_t model(vec_t v);
      vec_t r = v;
      bit   started, hdr_ok, op_ok, me;
      started  = (v.pre >= 32);
      hdr_ok   = started && v.st == 2'b01;
      op_ok    = hdr_ok && (v.op == 2'b10 || v.op == 2'b01);
      me       = op_ok && v.phy == 5'd1;
      r.e_busy = started ? 1 : 0;
      r.e_rd   = (me && v.op == 2'b10) ? 1 : 0;
      r.e_wr   = (me && v.op == 2'b01 && v.ta == 2'b10) ? 1 : 0;
      r.e_err  = ((started && !hdr_ok) || (hdr_ok && !op_ok) ||
                  (me && v.op == 2'b01 && v.ta != 2'b10)) ? 1 : 0;
      r.e_dat  = (v.op == 2'b10) ? (r.e_rd != 0 ? v.rd : 16'hFFFF) : v.wd;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      mgr_bit = b;
      tick(MDC_HALF);
      mdc = 1'b1;
      tick(MDC_HALF);
      mdc = 1'b0;
   endtask

   // drive one frame; reads release the bus and sample TA1, TA2 and 16 data
   // bits just before each rise. abort_i >= 0 pulses reset at that read bit.
   task automatic run_frame(input vec_t v, input int abort_i, output logic [17:0] rb);
      rb = 18'h3FFFF;
      mgr_oe = 1'b1;
      for (int i = 0; i < v.pre; i++) send_bit(1'b1);
      for (int k = 1; k >= 0; k--) send_bit(v.st[k]);
      for (int k = 1; k >= 0; k--) send_bit(v.op[k]);
      for (int k = 4; k >= 0; k--) send_bit(v.phy[k]);
      for (int k = 4; k >= 0; k--) send_bit(v.ra[k]);
      if (v.op != 2'b10) begin
         for (int k = 1; k >= 0; k--) send_bit(v.ta[k]);
         for (int k = 15; k >= 0; k--) send_bit(v.wd[k]);
      end else begin
         mgr_oe = 1'b0;
         for (int i = 0; i < 18; i++) begin
            tick(MDC_HALF);
            if (i == abort_i) begin
               chk("oe_before_rst", mdio_oe, 1'b1);
               rst_n = 1'b0;
               #1;
               chk("oe_in_rst", mdio_oe, 1'b0);
               chk("busy_in_rst", busy, 1'b0);
               tick(4);
               rst_n = 1'b1;
               break;
            end
            rb[17-i] = mdio_bus;
            mdc = 1'b1;
            tick(MDC_HALF);
            mdc = 1'b0;
         end
      end
      mgr_oe  = 1'b1;
      mgr_bit = 1'b1;
   endtask

   task automatic do_frame(input vec_t v, input string tag);
      int rd0, wr0, er0, oe0, bz0;
      logic [17:0] rb;
      rd0 = n_rd; wr0 = n_wr; er0 = n_err; oe0 = n_oe; bz0 = n_bz;
      reg_rdata = v.rd;
      run_frame(v, -1, rb);
      tick(24);
      chk($sformatf("%s rd_strobes", tag), n_rd - rd0, v.e_rd);
      chk($sformatf("%s wr_strobes", tag), n_wr - wr0, v.e_wr);
      chk($sformatf("%s frame_err", tag), n_err - er0, v.e_err);
      chk($sformatf("%s oe_seen", tag), (n_oe - oe0) > 0, v.e_rd != 0);
      chk($sformatf("%s busy_seen", tag), (n_bz - bz0) > 0, v.e_busy != 0);
      if (v.op == 2'b10) begin
         chk($sformatf("%s ta1", tag), rb[17], 1'b1);
         chk($sformatf("%s ta2", tag), rb[16], v.e_rd != 0 ? 1'b0 : 1'b1);
         chk($sformatf("%s rdata", tag), rb[15:0], v.e_dat);
      end
      if (v.e_rd != 0) chk($sformatf("%s rd_addr", tag), cap_addr, v.ra);
      if (v.e_wr != 0) begin
         chk($sformatf("%s wr_addr", tag), cap_addr, v.ra);
         chk($sformatf("%s wdata", tag), cap_wd, v.e_dat);
      end
      chk($sformatf("%s oe_after", tag), mdio_oe, 1'b0);
   endtask

   vec_t tbl[10];
   vec_t rv;
   logic [17:0] rb_ab;
   int   wr0, er0;

   initial begin
      rst_n = 1'b0; mdc = 1'b0; mgr_oe = 1'b1; mgr_bit = 1'b1; reg_rdata = 16'h0;

      //          pre st     op     phy   ra     ta     wd        rd       rd wr er bz dat
      tbl[0] = mk(32, 2'b01, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 16'h0141, 1, 0, 0, 1, 16'h0141);
      tbl[1] = mk(32, 2'b01, 2'b01, 5'd1, 5'h00, 2'b10, 16'h8000, 16'h0000, 0, 1, 0, 1, 16'h8000);
      tbl[2] = mk(32, 2'b01, 2'b10, 5'd7, 5'h02, 2'b00, 16'h0000, 16'h0141, 0, 0, 0, 1, 16'hFFFF);
      tbl[3] = mk(32, 2'b01, 2'b10, 5'd1, 5'h03, 2'b00, 16'h0000, 16'h1234, 1, 0, 0, 1, 16'h1234);
      tbl[4] = mk(31, 2'b01, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 16'hABCD, 0, 0, 0, 0, 16'hFFFF);
      tbl[5] = mk(32, 2'b01, 2'b11, 5'd1, 5'h02, 2'b10, 16'h1111, 16'h0000, 0, 0, 1, 1, 16'h1111);
      tbl[6] = mk(32, 2'b01, 2'b01, 5'd1, 5'h05, 2'b11, 16'h5A5A, 16'h0000, 0, 0, 1, 1, 16'h5A5A);
      tbl[7] = mk(32, 2'b00, 2'b01, 5'd1, 5'h05, 2'b10, 16'h00FF, 16'h0000, 0, 0, 1, 1, 16'h00FF);
      tbl[8] = mk(32, 2'b01, 2'b10, 5'd1, 5'h04, 2'b00, 16'h0000, 16'hBEEF, 1, 0, 0, 1, 16'hBEEF);
      tbl[9] = mk( 0, 2'b01, 2'b10, 5'd1, 5'h04, 2'b00, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 16'hFFFF);

      // reset state
      tick(5);
      chk("rst mdio_oe", mdio_oe, 1'b0);
      chk("rst mdio_o", mdio_o, 1'b0);
      chk("rst strobes", {reg_wr_en, reg_rd_en, frame_err, busy}, 4'b0);
      chk("rst reg_addr", reg_addr, 5'd0);
      chk("rst reg_wdata", reg_wdata, 16'd0);
      rst_n = 1'b1;
      tick(5);

      for (int i = 0; i < 10; i++) do_frame(tbl[i], $sformatf("vec%0d", i));

      // reset during read data bit 8, then a full read must still work
      wr0 = n_wr; er0 = n_err;
      rv = mk(32, 2'b01, 2'b10, 5'd1, 5'h06, 2'b00, 16'h0000, 16'h7E81, 1, 0, 0, 1, 16'h7E81);
      reg_rdata = rv.rd;
      run_frame(rv, 9, rb_ab);
      tick(10);
      chk("abort no_wr", n_wr - wr0, 0);
      chk("abort no_err", n_err - er0, 0);
      chk("abort oe_after", mdio_oe, 1'b0);
      rv = mk(32, 2'b01, 2'b10, 5'd1, 5'h09, 2'b00, 16'h0000, 16'h3C5A, 0, 0, 0, 0, 16'h0);
      do_frame(model(rv), "post_rst");

      // random frames against the reference model
      for (int n = 0; n < 30; n++) begin
         rv.pre = 32 + int'($urandom_range(0, 8));
         rv.st  = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
         case ($urandom_range(0, 5))
            0:       rv.op = 2'b11;
            1:       rv.op = 2'b00;
            2, 3:    rv.op = 2'b10;
            default: rv.op = 2'b01;
         endcase
         rv.phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd1;
         rv.ra  = 5'($urandom);
         rv.ta  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
         rv.wd  = 16'($urandom);
         rv.rd  = 16'($urandom);
         do_frame(model(rv), $sformatf("rnd%0d", n));
      end

      chk("never_both_strobes", n_both, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: the responder's Clause-22 PHY address.
REQ-002 SHALL have parameter PREAMBLE_MIN, default 32: the number of consecutive 1 bits required before ST.
REQ-003 SHALL have port clk, input, 1: the single system clock, which SHALL be at least 8x the MDC frequency.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port mdc_i, input, 1: the management clock from the MDIO manager, asynchronous to clk.
REQ-006 SHALL have port mdio_i, input, 1: the MDIO pad input, asynchronous to clk.
REQ-007 SHALL have port mdio_o, output, 1: the MDIO drive value.
REQ-008 SHALL have port mdio_oe, output, 1: the MDIO output enable; 1 drives the pad.
REQ-009 SHALL have port reg_addr, output, 5: the register address of the current access.
REQ-010 SHALL have port reg_wdata, output, 16: the write data.
REQ-011 SHALL have port reg_wr_en, output, 1: a one-clk write strobe.
REQ-012 SHALL have port reg_rd_en, output, 1: a one-clk read strobe.
REQ-013 SHALL have port reg_rdata, input, 16: the read data, valid on the clk after reg_rd_en.
REQ-014 SHALL have port frame_err, output, 1: a one-clk pulse on a malformed frame.
REQ-015 SHALL have port busy, output, 1: high from the ST bit to the end of the frame.

Function
REQ-016 SHALL pass mdc_i and mdio_i through 2-flop synchronizers; MDC rise/fall SHALL be detected from the synchronized mdc_i vs. its previous value.
REQ-017 SHALL sample mdio on each detected MDC rise and update mdio_o/mdio_oe on the clk after a detected MDC fall.
REQ-018 SHALL implement the FSM PREAMBLE -> ST -> OP -> PHYAD -> REGAD -> TA -> DATA -> PREAMBLE, plus SKIP.
REQ-019 PREAMBLE: a saturating ones-counter (6 bits) SHALL clear on a sampled 0; a 0 sampled with count >= PREAMBLE_MIN SHALL be taken as ST bit 1 and enter ST; a 0 sampled with count < PREAMBLE_MIN SHALL be ignored with no error.
REQ-020 ST: the second bit SHALL be 1, else frame_err and return to PREAMBLE.
REQ-021 OP: 2 bits, MSB first; 10 = read, 01 = write; 00 or 11 SHALL give frame_err and return to PREAMBLE.
REQ-022 PHYAD and REGAD: 5 bits each, MSB first; reg_addr SHALL update once REGAD is complete.
REQ-023 PHYAD != PHY_ADDR: enter SKIP after REGAD, count 18 rises (TA+data) with mdio_oe=0 throughout and no strobes, then return to PREAMBLE.
REQ-024 Read: reg_rd_en SHALL pulse on the clk after the last REGAD rise, and reg_rdata SHALL be latched into the shift register on the next clk.
REQ-025 Read: mdio_oe SHALL stay 0 during TA bit 1; on the fall ending TA bit 1, drive mdio_oe=1, mdio_o=0.
REQ-026 Read: on each of the following 16 falls, drive data bits 15 down to 0.
REQ-027 Read: on the fall after bit 0 has been presented for a full MDC period, mdio_oe SHALL return to 0.
REQ-028 Write: the TA bits SHALL sample as 1,0, else frame_err, skip the 16 data bits (SKIP), and assert no strobe.
REQ-029 Write: shift 16 data bits MSB first, then pulse reg_wr_en for one clk with reg_wdata and reg_addr stable.
REQ-030 After every frame (good, skipped or errored) the ones-counter SHALL be 0; a new full preamble is required.
REQ-031 mdio_oe SHALL never be 1 outside the read TA bit 2 and DATA state for a matching PHYAD.
REQ-032 busy SHALL be 0 in PREAMBLE, and 1 otherwise.
REQ-033 reg_wr_en and reg_rd_en SHALL never be high in the same clk.

Reset
REQ-034 rst_n low SHALL immediately force state=PREAMBLE, counters=0, mdio_oe=0, mdio_o=0, reg_wr_en=0, reg_rd_en=0, frame_err=0, busy=0, reg_addr=0, reg_wdata=0, and synchronizers=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no strobe, and mdio_oe SHALL drop within 0 clk; after release the responder SHALL require a full preamble.

Verification
REQ-036 Read: 32 ones, ST=01, OP=10, PHYAD=1, REGAD=0x02, reg_rdata=0x0141 -> one reg_rd_en with reg_addr=2; the bench samples TA bit 2 = 0 then 0x0141 MSB first; mdio_oe=0 after the frame.
REQ-037 Write: preamble, OP=01, PHYAD=1, REGAD=0x00, TA=10, data 0x8000 -> one reg_wr_en, reg_addr=0, reg_wdata=0x8000; mdio_oe stays 0 throughout.
REQ-038 PHYAD=7 read -> no strobes, mdio_oe=0 for the whole frame, then a following valid frame to PHYAD 1 is answered.
REQ-039 Preamble of 31 ones then ST -> ignored (no busy, no strobe, no frame_err); OP=11 after a valid preamble -> one frame_err pulse.
REQ-040 Write with TA=11 -> frame_err pulse and no reg_wr_en; two back-to-back reads without an intervening preamble -> only the first is answered.
REQ-041 rst_n low during read DATA bit 8 -> mdio_oe=0 immediately; after release a full read frame returns the correct data.
